particle_transform_scheduler: RTL

- Sequences one frame of particle positions through the shared transform_position pipeline.
- Reads positions from particle BRAM by index, issues them to the transform pipeline and buffers the screen-space results in a local FIFO.
- Presents results to the pixel writer over a ready/valid handshake.
- Uses credit-based issue, so results are never lost when the pixel writer stalls; the transform pipeline has no backpressure.

---
 rtl/particle_transform_scheduler.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/particle_transform_scheduler.sv
// particle_transform_scheduler
//   Walks one frame of particle positions out of particle BRAM, feeds them to
//   the shared transform_position pipeline and buffers the screen-space
//   results in a small FIFO in front of the pixel writer.
//
//   Issue is credit based: a read is only started when the reads still in
//   flight plus the words already in the FIFO leave room for its result.
//   This matters because the transform pipeline cannot be stalled.
//
// Ports
//   clk_in, rst          clock, synchronous active-high reset
//   frame_start_in       pulse, starts a frame (IDLE only)
//   num_particles_in     particle count, sampled with frame_start_in
//   particle_addr_out    BRAM read address (current issue index)
//   particle_rd_en_out   BRAM read strobe
//   particle_data_in     BRAM data, MEM_LATENCY cycles after the strobe
//   xform_f_out          combinational copy of particle_data_in
//   xform_valid_out      read strobe delayed to line up with particle_data_in
//   xform_result_in      transform result
//   xform_valid_in       transform result valid
//   pixel_out            FIFO head entry
//   pixel_valid_out      FIFO non-empty
//   pixel_ready_in       pixel writer accepts pixel_out
//   busy_out             high whenever the FSM is not IDLE
//   frame_done_out       one-cycle pulse when a frame has fully drained
//
// Handshake: a pixel transfers in every cycle where pixel_valid_out and
// pixel_ready_in are both high; pixel_out is held stable while
// pixel_valid_out is high and pixel_ready_in is low.
module particle_transform_scheduler #(
    parameter int DIMS        = 2,
    parameter int ADDR_W      = 12,
    parameter int MEM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 frame_start_in,
    input  logic [ADDR_W:0]      num_particles_in,
    output logic [ADDR_W-1:0]    particle_addr_out,
    output logic                 particle_rd_en_out,
    input  logic [DIMS*16-1:0]   particle_data_in,
    output logic [DIMS*16-1:0]   xform_f_out,
    output logic                 xform_valid_out,
    input  logic [DIMS*32-1:0]   xform_result_in,
    input  logic                 xform_valid_in,
    output logic [DIMS*32-1:0]   pixel_out,
    output logic                 pixel_valid_out,
    input  logic                 pixel_ready_in,
    output logic                 busy_out,
    output logic                 frame_done_out
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                 state, state_nx;
    logic [ADDR_W:0]        n_q;
    logic [ADDR_W:0]        issued;
    logic [CW-1:0]          inflight;
    logic [CW-1:0]          fifo_count;
    logic [MEM_LATENCY-1:0] vld_sr;
    logic [DIMS*32-1:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic                   frame_done_q;

    logic credit_ok, issue, accept_res, pop, push, full;

    // Every read holds one credit until its result lands in the FIFO, and
    // every FIFO word holds one until the pixel writer takes it.
    assign credit_ok  = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
    assign issue      = (state == ISSUE) && (issued < n_q) && credit_ok;
    // A result with nothing in flight is left over from before a reset.
    assign accept_res = xform_valid_in && (inflight != '0);
    assign pop        = (fifo_count != '0) && pixel_ready_in;
    assign full       = (fifo_count == CW'(FIFO_DEPTH));
    // Push into a full FIFO only works when the head leaves the same cycle;
    // otherwise the word is dropped (cannot happen while credits hold).
    assign push       = accept_res && (!full || pop);

    assign particle_rd_en_out = issue;
    assign particle_addr_out  = issued[ADDR_W-1:0];
    assign xform_f_out        = particle_data_in;
    assign xform_valid_out    = vld_sr[MEM_LATENCY-1];
    assign pixel_out          = mem[rd_ptr];
    assign pixel_valid_out    = (fifo_count != '0);
    assign busy_out           = (state != IDLE);
    assign frame_done_out     = frame_done_q;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (frame_start_in) begin
                    state_nx = (num_particles_in == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (issued == n_q) state_nx = DRAIN;
            end
            DRAIN: begin
                if ((inflight == '0) && (fifo_count == '0)) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state        <= IDLE;
            n_q          <= '0;
            issued       <= '0;
            inflight     <= '0;
            fifo_count   <= '0;
            vld_sr       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            state <= state_nx;
            // The pulse is registered so it appears in the first IDLE cycle,
            // i.e. together with busy_out falling.
            frame_done_q <= (state == DONE);

            if ((state == IDLE) && frame_start_in) begin
                n_q    <= num_particles_in;
                issued <= '0;
            end else if (issue) begin
                issued <= issued + 1'b1;
            end

            vld_sr[0] <= issue;
            for (int i = 1; i < MEM_LATENCY; i++) vld_sr[i] <= vld_sr[i-1];

            case ({issue, accept_res})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase

            if (push) begin
                mem[wr_ptr] <= xform_result_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
